// File: rtl/voting_machine_param.sv
// voting_machine_param
// Counts one vote per button press for N_CAND candidates, rejects
// multi-button presses, saturates every counter, and on entering result
// mode scans the candidates one per cycle to find the winner(s).
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   mode              0=IDLE 1=VOTE 2=RESULT 3=CLEAR
//   in_candidate      debounced vote buttons (level)
//   count_bus         candidate i count at [i*CNT_W +: CNT_W]
//   total_votes       accepted votes (saturating)
//   invalid_votes     rejected multi-button presses (saturating)
//   vote_ack/vote_err one-cycle accept / reject-or-drop pulses
//   sat_flag          sticky: some candidate count hit its maximum
//   winner, tie       scan result, valid while result_valid is high

// Per-candidate saturating counter.
module voting_cand_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max,
    output logic             near_max
);
    assign at_max   = (cnt == {CNT_W{1'b1}});
    assign near_max = (cnt == {{(CNT_W-1){1'b1}}, 1'b0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end
endmodule

module voting_machine_param #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8,
    parameter int TOT_W  = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [N_CAND-1:0]         in_candidate,
    output logic [N_CAND*CNT_W-1:0]   count_bus,
    output logic [TOT_W-1:0]          total_votes,
    output logic [TOT_W-1:0]          invalid_votes,
    output logic                      vote_ack,
    output logic                      vote_err,
    output logic                      sat_flag,
    output logic [N_CAND-1:0]         winner,
    output logic                      tie,
    output logic                      result_valid
);
    localparam int IDX_W = $clog2(N_CAND);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

    typedef enum logic [1:0] {S_IDLE, S_VOTE, S_SCAN, S_DONE} state_t;

    state_t                         state;
    logic [N_CAND-1:0]              btn_q;
    logic [N_CAND-1:0]              rise;
    logic [N_CAND-1:0]              cnt_max;
    logic [N_CAND-1:0]              cnt_near;
    logic [N_CAND-1:0]              inc;
    logic [N_CAND-1:0][CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]               idx;
    logic [CNT_W-1:0]               best;
    logic [CNT_W-1:0]               cur;
    logic [N_CAND-1:0]              idx_bit;
    logic                           clr;
    logic                           vote_en;
    logic                           any_rise;
    logic                           one_hot;
    logic                           accept;
    logic                           reject;
    logic                           full;
    logic                           hits_max;
    logic                           total_full;
    logic                           invalid_full;

    assign clr      = (mode == 2'd3);
    // Clear takes priority over a press landing on the same edge.
    assign vote_en  = (state == S_VOTE) && !clr;
    assign rise     = in_candidate & ~btn_q;
    assign any_rise = |rise;
    assign one_hot  = $onehot(in_candidate);
    assign accept   = vote_en && any_rise && one_hot;
    // rise != 0 implies in_candidate != 0, so "not one-hot" means >1 bit set.
    assign reject   = vote_en && any_rise && !one_hot;
    // in_candidate is one-hot when these are used, so the AND selects one lane.
    assign full     = |(in_candidate & cnt_max);
    assign hits_max = |(in_candidate & cnt_near);
    assign inc      = accept ? in_candidate : '0;

    assign total_full   = (total_votes   == {TOT_W{1'b1}});
    assign invalid_full = (invalid_votes == {TOT_W{1'b1}});

    assign cur     = cnt[idx];
    assign idx_bit = N_CAND'(1) << idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_CAND; gi++) begin : g_cand
            voting_cand_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .clr      (clr),
                .inc      (inc[gi]),
                .cnt      (cnt[gi]),
                .at_max   (cnt_max[gi]),
                .near_max (cnt_near[gi])
            );
            assign count_bus[gi*CNT_W +: CNT_W] = cnt[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            btn_q         <= '0;
            idx           <= '0;
            best          <= '0;
            total_votes   <= '0;
            invalid_votes <= '0;
            vote_ack      <= 1'b0;
            vote_err      <= 1'b0;
            sat_flag      <= 1'b0;
            winner        <= '0;
            tie           <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            // Tracks buttons in every state so a held button never counts twice.
            btn_q    <= in_candidate;
            vote_ack <= 1'b0;
            vote_err <= 1'b0;

            if (accept) begin
                if (full) begin
                    vote_err <= 1'b1;
                    sat_flag <= 1'b1;
                end else begin
                    vote_ack <= 1'b1;
                    if (!total_full)
                        total_votes <= total_votes + 1'b1;
                    if (hits_max)
                        sat_flag <= 1'b1;
                end
            end
            if (reject) begin
                vote_err <= 1'b1;
                if (!invalid_full)
                    invalid_votes <= invalid_votes + 1'b1;
            end

            case (state)
                S_IDLE, S_VOTE: begin
                    case (mode)
                        2'd1: state <= S_VOTE;
                        2'd2: begin
                            state  <= S_SCAN;
                            idx    <= '0;
                            winner <= '0;
                            tie    <= 1'b0;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_SCAN: begin
                    if (mode == 2'd2) begin
                        if (idx == '0 || cur > best) begin
                            best   <= cur;
                            winner <= idx_bit;
                            tie    <= 1'b0;
                        end else if (cur == best) begin
                            winner <= winner | idx_bit;
                            tie    <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                            // Empty ballot: later NBA overrides the scan result.
                            if (total_votes == '0) begin
                                winner <= '0;
                                tie    <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        state        <= (mode == 2'd1) ? S_VOTE : S_IDLE;
                        winner       <= '0;
                        tie          <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (mode != 2'd2) begin
                        state        <= (mode == 2'd1) ? S_VOTE : S_IDLE;
                        winner       <= '0;
                        tie          <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (clr) begin
                total_votes   <= '0;
                invalid_votes <= '0;
                sat_flag      <= 1'b0;
                winner        <= '0;
                tie           <= 1'b0;
                result_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/voting_machine_param.md
# voting_machine_param

Parametrised successor to the team's three-candidate voting machine. It counts votes for N_CAND candidates from button inputs, with one vote per press, and rejects multi-button presses. Per-candidate counts saturate. When result mode is entered, a sequential scan finds the winner or winners and flags ties. It sits between the debounced front-panel buttons and the display/result logic.

## Interface
- N_CAND, 4, number of candidates (2..16)
- CNT_W, 8, width of each candidate count
- TOT_W, 12, width of total and invalid counters
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0=IDLE, 1=VOTE, 2=RESULT, 3=CLEAR
- in_candidate  in  N_CAND  vote buttons, level, already debounced
- count_bus  out  N_CAND*CNT_W  candidate i count at [i*CNT_W +: CNT_W]
- total_votes  out  TOT_W  accepted votes
- invalid_votes  out  TOT_W  rejected multi-button presses
- vote_ack  out  1  one-cycle pulse, vote accepted
- vote_err  out  1  one-cycle pulse, press rejected or dropped
- sat_flag  out  1  sticky, some count reached 2^CNT_W-1
- winner  out  N_CAND  one-hot (or multi-hot on tie) winner flags
- tie  out  1  more than one candidate holds the maximum
- result_valid  out  1  winner/tie valid

## Operation
- FSM states: S_IDLE, S_VOTE, S_SCAN, S_DONE. Reset puts the FSM in S_IDLE. Every output and register resets to 0, including btn_q.
- btn_q registers in_candidate every cycle, in every state. A rising edge on bit i is `rise[i] = in_candidate[i] & ~btn_q[i]`.
- Accept rule in S_VOTE: if rise != 0 and in_candidate is one-hot, bit i is accepted.
  - If count[i] < max, count[i]+1 and total+1 (total saturates at max), and vote_ack pulses.
  - If count[i] == max, the vote is dropped, vote_err pulses, and sat_flag sets.
- Reject rule in S_VOTE: if rise != 0 and popcount(in_candidate) > 1, invalid_votes+1 (saturating) and vote_err pulses. No count changes.
- A button held high across cycles counts once. A new vote needs a release (at least one cycle low) and then a press again.
- Rising edges in S_IDLE, S_SCAN or S_DONE are ignored. btn_q still tracks the buttons, so a button held through a switch into VOTE does not count.
- Transitions:
  - mode 0 → S_IDLE, mode 1 → S_VOTE.
  - mode 2 from S_IDLE or S_VOTE → S_SCAN.
  - mode 3 from any state → S_IDLE.
- mode 3 clears count_bus, total, invalid, sat_flag, winner, tie and result_valid on every edge while it is held.
- Scan runs over idx = 0..N_CAND-1, one candidate per cycle:
  - idx 0 loads best = count[0] and sets winner to bit 0.
  - count[idx] > best sets best = count[idx], winner to bit idx only, and tie = 0.
  - count[idx] == best ORs bit idx into winner and sets tie = 1.
- After idx N_CAND-1 the FSM moves to S_DONE and result_valid = 1.
  - If total_votes == 0, winner = 0 and tie = 0 at S_DONE.
- In S_SCAN or S_DONE, mode != 2 goes to the state that mode names and clears winner, tie and result_valid on the same edge.

## Timing
- A vote updates on the same edge that samples the rise. count_bus, total_votes and vote_ack are visible the following cycle. vote_ack/vote_err are high for exactly 1 cycle.
- mode 2 sampled at edge k gives S_SCAN at k. result_valid rises after edge k+N_CAND and stays high while mode == 2.
- Simultaneous rise of two buttons, or a rise while another is held: reject.
- Reset asserted mid-scan or mid-vote: immediate clear of all outputs. After release the FSM is in S_IDLE and the next mode is honoured on the first edge.
- Counts persist across IDLE/VOTE/RESULT. Only reset or mode 3 clears them.

## Test plan
- Reset with mode=1, then press candidates 0,2,1,0 as 1-cycle pulses separated by 1-cycle gaps → count_bus = {c3=0, c2=1, c1=1, c0=2}, total=4, four vote_ack pulses.
- Hold candidate 1 high for 5 cycles → count[1] +1 only. Press 1 and 3 in the same cycle → invalid_votes=1, vote_err pulse, counts unchanged.
- Votes 0:3, 1:5, 2:5, 3:1, then mode=2 → result_valid exactly 4 cycles after the mode-2 edge, winner=4'b0110, tie=1. Then mode=1 → result_valid=0 the next cycle.
- Drive count[0] to 255 with CNT_W=8 → 256th press is dropped, vote_err pulses, sat_flag=1, count stays 255.
- No votes cast, then mode=2 → winner=0, tie=0, result_valid=1. Then mode=3 for 1 cycle → all counters, flags and results are 0.
- Assert reset during S_SCAN → all outputs 0 in the same cycle. After release, mode=2 restarts the full N_CAND-cycle scan.
